// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch stage: opcode encodings, field positions,
// default widths and the fetch FSM state encoding.
package isa_pkg;
   localparam int ADDR_WIDTH_D = 10;
   localparam int DATA_WIDTH_D = 32;
   localparam int MEM_DEPTH_D  = 83;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 26;

   localparam logic [5:0] OP_JUMP   = 6'b010101;
   localparam logic [5:0] OP_BRZ    = 6'b010011;
   localparam logic [5:0] OP_PREBR  = 6'b011111;
   localparam logic [5:0] OP_HLT    = 6'b011100;
   localparam logic [5:0] OP_NOP    = 6'b011011;
   localparam logic [5:0] OP_LOADI  = 6'b010000;
   localparam logic [5:0] OP_INPUT  = 6'b010001;
   localparam logic [5:0] OP_OUTPUT = 6'b010010;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch stage; flags any next PC that
// falls outside the populated instruction memory.
module next_pc_logic
   import isa_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_D,
   parameter int MEM_DEPTH  = MEM_DEPTH_D
) (
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [5:0]            opcode,
   input  logic [ADDR_WIDTH-1:0] target,
   input  logic                  branch_zero,
   output logic [ADDR_WIDTH-1:0] next_pc,
   output logic                  fault_next,
   output logic                  halt_next
);
   logic [ADDR_WIDTH:0] seq_pc;
   logic [ADDR_WIDTH:0] nxt;

   // One extra bit so a wrap past the top of the address space shows up as a fault.
   assign seq_pc = {1'b0, pc} + (ADDR_WIDTH+1)'(1);

   always_comb begin
      nxt       = seq_pc;
      halt_next = 1'b0;
      case (opcode)
         OP_JUMP: nxt = {1'b0, target};
         OP_BRZ:  if (branch_zero) nxt = {1'b0, target};
         OP_HLT: begin
            nxt       = {1'b0, pc};
            halt_next = 1'b1;
         end
         default: ;
      endcase
   end

   assign fault_next = (nxt >= (ADDR_WIDTH+1)'(MEM_DEPTH));
   assign next_pc    = nxt[ADDR_WIDTH-1:0];
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC register, instruction register and fetch FSM. Jumps, branches and halt are
// resolved on the RAM output directly so redirects cost no bubble.
module instruction_fetch_unit
   import isa_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_D,
   parameter int DATA_WIDTH = DATA_WIDTH_D,
   parameter int MEM_DEPTH  = MEM_DEPTH_D
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stall,
   input  logic                  zero_flag,
   input  logic [DATA_WIDTH-1:0] instruction_in,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] instruction_out,
   output logic [ADDR_WIDTH-1:0] instruction_pc,
   output logic                  instruction_valid,
   output logic                  halted,
   output logic                  fault
);
   fetch_state_e          state;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  branch_zero;
   logic                  prebr_live;
   logic                  bz_eff;
   logic [ADDR_WIDTH-1:0] next_pc;
   logic                  fault_next;
   logic                  halt_next;

   // A BRZ fetched right behind its PREBR must see this cycle's flag, not the latch.
   assign prebr_live = instruction_valid && (instruction_out[OP_MSB:OP_LSB] == OP_PREBR);
   assign bz_eff     = prebr_live ? zero_flag : branch_zero;

   next_pc_logic #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_next_pc (
      .pc          (pc),
      .opcode      (instruction_in[OP_MSB:OP_LSB]),
      .target      (instruction_in[ADDR_WIDTH-1:0]),
      .branch_zero (bz_eff),
      .next_pc     (next_pc),
      .fault_next  (fault_next),
      .halt_next   (halt_next)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state             <= S_IDLE;
         pc                <= '0;
         instruction_out   <= '0;
         instruction_pc    <= '0;
         instruction_valid <= 1'b0;
         branch_zero       <= 1'b0;
         fault             <= 1'b0;
      end else begin
         instruction_valid <= 1'b0;
         case (state)
            S_IDLE: if (start) state <= S_RUN;
            S_RUN: if (!stall) begin
               instruction_out   <= instruction_in;
               instruction_pc    <= pc;
               instruction_valid <= 1'b1;
               if (prebr_live) branch_zero <= zero_flag;
               // The faulting instruction still issues; only the PC freezes.
               if (fault_next) begin
                  fault <= 1'b1;
                  state <= S_HALTED;
               end else begin
                  pc <= next_pc;
                  if (halt_next) state <= S_HALTED;
               end
            end
            default: ;
         endcase
      end
   end

   assign address = pc;
   assign halted  = (state == S_HALTED);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: behavioural fetch model plus directed address-sequence
// checks and randomized programs with random stall / zero_flag.
module tb_instruction_fetch_unit;
   localparam logic [5:0] T_JUMP  = 6'b010101;
   localparam logic [5:0] T_BRZ   = 6'b010011;
   localparam logic [5:0] T_PREBR = 6'b011111;
   localparam logic [5:0] T_HLT   = 6'b011100;
   localparam logic [5:0] T_NOP   = 6'b011011;
   localparam logic [5:0] T_LOADI = 6'b010000;
   localparam int DEPTH = 83;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        zero_flag = 1'b0;
   logic [31:0] instruction_in;
   logic [9:0]  address;
   logic [31:0] instruction_out;
   logic [9:0]  instruction_pc;
   logic        instruction_valid;
   logic        halted;
   logic        fault;

   logic [31:0] mem [0:1023];

   int checks = 0;
   int fails  = 0;

   // model state: st 0=idle 1=run 2=halted
   int          m_st, m_pc, m_ipc;
   logic [31:0] m_out;
   bit          m_valid, m_bz, m_fault;

   int alog[$];
   int vlog[$];
   int hlog[$];
   int flog[$];

   always #5 clock = ~clock;
   assign instruction_in = mem[address];

   instruction_fetch_unit dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .stall             (stall),
      .zero_flag         (zero_flag),
      .instruction_in    (instruction_in),
      .address           (address),
      .instruction_out   (instruction_out),
      .instruction_pc    (instruction_pc),
      .instruction_valid (instruction_valid),
      .halted            (halted),
      .fault             (fault)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ins(input logic [5:0] op, input int tgt);
      logic [31:0] w;
      w = '0;
      w[31:26] = op;
      w[9:0] = tgt[9:0];
      return w;
   endfunction

   function automatic logic [31:0] rand_ins();
      int p;
      logic [31:0] w;
      p = $urandom_range(0, 99);
      w = $urandom;
      if (p < 55)      w[31:26] = T_NOP;
      else if (p < 65) w[31:26] = T_JUMP;
      else if (p < 77) w[31:26] = T_BRZ;
      else if (p < 92) w[31:26] = T_PREBR;
      else if (p < 93) w[31:26] = T_HLT;
      else             w[31:26] = T_LOADI + 6'($urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) w[9:0] = 10'($urandom_range(DEPTH, 1023));
      else                            w[9:0] = 10'($urandom_range(0, DEPTH-1));
      return w;
   endfunction

   task automatic model_reset();
      m_st = 0; m_pc = 0; m_ipc = 0; m_out = '0;
      m_valid = 0; m_bz = 0; m_fault = 0;
   endtask

   // Advance the model by one rising edge with the inputs now applied.
   task automatic model_step();
      logic [31:0] w;
      int np, tgt;
      bit fwd, bz;
      if (m_st == 1 && !stall) begin
         w   = mem[m_pc];
         tgt = int'(w[9:0]);
         fwd = m_valid && (m_out[31:26] == T_PREBR);
         bz  = fwd ? zero_flag : m_bz;
         if (fwd) m_bz = zero_flag;
         if (w[31:26] == T_JUMP)                np = tgt;
         else if (w[31:26] == T_BRZ && bz)      np = tgt;
         else if (w[31:26] == T_HLT)            np = m_pc;
         else                                   np = m_pc + 1;
         m_out = w; m_ipc = m_pc; m_valid = 1;
         if (np >= DEPTH) begin
            m_fault = 1; m_st = 2;
         end else begin
            m_pc = np;
            if (w[31:26] == T_HLT) m_st = 2;
         end
      end else begin
         m_valid = 0;
         if (m_st == 0 && start) m_st = 1;
      end
   endtask

   // The single compare point: outputs vs model at the falling edge, then new inputs.
   task automatic cyc(input bit st, input bit sl, input bit zf);
      @(negedge clock);
      chk("address", 32'(address), 32'(m_pc));
      chk("instruction_out", instruction_out, m_out);
      chk("instruction_pc", 32'(instruction_pc), 32'(m_ipc));
      chk("instruction_valid", 32'(instruction_valid), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_st == 2));
      chk("fault", 32'(fault), 32'(m_fault));
      alog.push_back(int'(address));
      vlog.push_back(int'(instruction_valid));
      hlog.push_back(int'(halted));
      flog.push_back(int'(fault));
      start = st; stall = sl; zero_flag = zf;
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0; start = 1'b0; stall = 1'b0; zero_flag = 1'b0;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 1024; i++) mem[i] = ins(T_NOP, 0);
   endtask

   task automatic boot();
      do_reset();
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      alog.delete(); vlog.delete(); hlog.delete(); flog.delete();
   endtask

   task automatic run(input int n, input bit sl, input bit zf);
      for (int i = 0; i < n; i++) cyc(0, sl, zf);
   endtask

   initial begin
      model_reset();
      fill_nop();

      // reset values and straight-line fetch
      do_reset();
      #1;
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_valid", 32'(instruction_valid), 32'd0);
      boot();
      run(5, 0, 0);
      chk("nop_a0", alog[0], 0);
      chk("nop_a1", alog[1], 1);
      chk("nop_a2", alog[2], 2);
      chk("nop_a3", alog[3], 3);
      chk("nop_v0", vlog[0], 0);
      chk("nop_v1", vlog[1], 1);

      // jump without bubble
      fill_nop();
      mem[5] = ins(T_JUMP, 20);
      boot();
      run(8, 0, 0);
      chk("jmp_a4", alog[4], 4);
      chk("jmp_a5", alog[5], 5);
      chk("jmp_a6", alog[6], 20);
      chk("jmp_a7", alog[7], 21);

      // PREBR then BRZ, taken and not taken
      fill_nop();
      mem[9]  = ins(T_PREBR, 0);
      mem[10] = ins(T_BRZ, 1);
      boot();
      run(12, 0, 1);
      chk("brz1_a10", alog[10], 10);
      chk("brz1_a11", alog[11], 1);
      boot();
      run(12, 0, 0);
      chk("brz0_a10", alog[10], 10);
      chk("brz0_a11", alog[11], 11);

      // stall at address 7
      fill_nop();
      boot();
      run(7, 0, 0);
      run(3, 1, 0);
      run(2, 0, 0);
      chk("stall_a9", alog[9], 7);
      chk("stall_a10", alog[10], 7);
      chk("stall_v9", vlog[9], 0);
      chk("stall_a11", alog[11], 8);
      chk("stall_v11", vlog[11], 1);

      // halt at 81, start ignored, async reset clears everything
      fill_nop();
      mem[81] = ins(T_HLT, 0);
      boot();
      run(84, 0, 0);
      chk("hlt_a81", alog[81], 81);
      chk("hlt_h81", hlog[81], 0);
      chk("hlt_h82", hlog[82], 1);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("hlt_start_addr", alog[alog.size()-1], 81);
      chk("hlt_start_halt", hlog[hlog.size()-1], 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_address", 32'(address), 32'd0);
      chk("arst_out", instruction_out, 32'd0);
      chk("arst_pc", 32'(instruction_pc), 32'd0);
      chk("arst_halted", 32'(halted), 32'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;

      // out-of-range jump target
      fill_nop();
      mem[3] = ins(T_JUMP, 100);
      boot();
      run(6, 0, 0);
      chk("fjmp_a4", alog[4], 3);
      chk("fjmp_f4", flog[4], 1);
      chk("fjmp_h4", hlog[4], 1);
      chk("fjmp_v4", vlog[4], 1);
      chk("fjmp_v5", vlog[5], 0);

      // sequential overrun past the last word
      fill_nop();
      boot();
      run(86, 0, 0);
      chk("fseq_a82", alog[82], 82);
      chk("fseq_f82", flog[82], 0);
      chk("fseq_a83", alog[83], 82);
      chk("fseq_f83", flog[83], 1);

      // randomized programs
      for (int r = 0; r < 15; r++) begin
         for (int i = 0; i < 1024; i++) mem[i] = rand_ins();
         boot();
         for (int c = 0; c < 250; c++)
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
